// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle for clk_div_ctrl: run request, ratio-change
// handshake and the divided clock outputs.
interface clk_div_ctrl_if #(
    parameter int unsigned BIT_SIZE = 10
);
    logic                enable;
    logic                div_req;
    logic [BIT_SIZE-1:0] div_val;
    logic                div_ready;
    logic                div_ack;
    logic                div_err;
    logic                clk_out;
    logic                tick;
    logic                busy;

    modport master (
        output enable, div_req, div_val,
        input  div_ready, div_ack, div_err, clk_out, tick, busy
    );

    modport slave (
        input  enable, div_req, div_val,
        output div_ready, div_ack, div_err, clk_out, tick, busy
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with a ratio-change handshake.
// The divided clock is high for active_div/2 cycles and low for the rest;
// new ratios are applied only on a period boundary.
// Optional feature: define CLK_DIV_CTRL_SOFT_STOP_EN to finish the current
// period before stopping (DRAIN); otherwise enable=0 freezes the divider.
module clk_div_ctrl #(
    parameter int unsigned BIT_SIZE    = 10,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic          clk_in,
    input  logic          reset,
    clk_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BIT_SIZE-1:0] cnt_q, cnt_d;
    logic [BIT_SIZE-1:0] active_div_q, active_div_d;
    logic [BIT_SIZE-1:0] pend_div_q, pend_div_d;
    logic                pending_q, pending_d;
    logic                clk_out_q, clk_out_d;
    logic                tick_q, tick_d;
    logic                div_ack_q, div_ack_d;
    logic                div_err_q, div_err_d;

    logic                at_wrap;
    logic                at_half;
    logic                accept;
    logic                div_valid;

    assign at_wrap   = (cnt_q == active_div_q - 1'b1);
    assign at_half   = (cnt_q == (active_div_q >> 1) - 1'b1);
    assign accept    = bus.div_req && !pending_q;
    assign div_valid = (bus.div_val >= BIT_SIZE'(2));

    // State register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, divided clock, ratio registers and handshake pulses
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q        <= '0;
            active_div_q <= BIT_SIZE'(DEFAULT_DIV);
            pend_div_q   <= '0;
            pending_q    <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            div_ack_q    <= 1'b0;
            div_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pending_q    <= pending_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            div_ack_q    <= div_ack_d;
            div_err_q    <= div_err_d;
        end
    end

    // Next-state, counting and ratio-change decisions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pending_d    = pending_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        div_ack_d    = 1'b0;
        div_err_d    = 1'b0;

        case (state_q)
            STOP: begin
                if (bus.enable) begin
                    state_d = RUN;
                end
                // A ratio accepted on the same edge the divider stopped is
                // still pending here; apply it before taking a new one.
                if (pending_q) begin
                    active_div_d = pend_div_q;
                    cnt_d        = '0;
                    pending_d    = 1'b0;
                    div_ack_d    = 1'b1;
                end else if (accept && div_valid) begin
                    active_div_d = bus.div_val;
                    cnt_d        = '0;
                    div_ack_d    = 1'b1;
                end
            end
            default: begin
`ifdef CLK_DIV_CTRL_SOFT_STOP_EN
                state_d = bus.enable ? RUN : DRAIN;
                if (at_wrap) begin
                    cnt_d = '0;
                    if (state_q == DRAIN && !bus.enable) begin
                        state_d   = STOP;
                        clk_out_d = 1'b0;
                    end else begin
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end
                    if (pending_q) begin
                        active_div_d = pend_div_q;
                        pending_d    = 1'b0;
                        div_ack_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (at_half) begin
                        clk_out_d = 1'b0;
                    end
                end
`else
                if (!bus.enable) begin
                    state_d = STOP;
                    // Frozen counter may exceed the new ratio, so restart
                    // the period from 0 when a pending ratio lands on stop.
                    if (pending_q) begin
                        active_div_d = pend_div_q;
                        cnt_d        = '0;
                        pending_d    = 1'b0;
                        div_ack_d    = 1'b1;
                    end
                end else if (at_wrap) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                    if (pending_q) begin
                        active_div_d = pend_div_q;
                        pending_d    = 1'b0;
                        div_ack_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (at_half) begin
                        clk_out_d = 1'b0;
                    end
                end
`endif
            end
        endcase

        // Invalid ratios are rejected in any state; valid ones made while
        // running wait for the period boundary.
        if (accept && !div_valid) begin
            div_err_d = 1'b1;
        end else if (accept && state_q != STOP) begin
            pend_div_d = bus.div_val;
            pending_d  = 1'b1;
        end
    end

    assign bus.div_ready = !pending_q;
    assign bus.div_ack   = div_ack_q;
    assign bus.div_err   = div_err_q;
    assign bus.clk_out   = clk_out_q;
    assign bus.tick      = tick_q;
    assign bus.busy      = (state_q != STOP);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (BIT_SIZE=10, DEFAULT_DIV=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_clk_div_ctrl;

    logic clk;
    logic reset;
    int unsigned n_tests;
    int unsigned n_fail;

    clk_div_ctrl_if #(.BIT_SIZE(10)) bus ();

    clk_div_ctrl #(
        .BIT_SIZE    (10),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance one edge, check every output.
    task automatic cyc(input string name, input bit rst, input bit en, input bit req,
                       input logic [9:0] val, input bit e_clk, input bit e_tick,
                       input bit e_ack, input bit e_err, input bit e_rdy, input bit e_busy);
        reset          = rst;
        bus.enable     = en;
        bus.div_req    = req;
        bus.div_val    = val;
        @(posedge clk);
        #1;
        check($sformatf("%s clk_out", name),   32'(bus.clk_out),   32'(e_clk));
        check($sformatf("%s tick", name),      32'(bus.tick),      32'(e_tick));
        check($sformatf("%s div_ack", name),   32'(bus.div_ack),   32'(e_ack));
        check($sformatf("%s div_err", name),   32'(bus.div_err),   32'(e_err));
        check($sformatf("%s div_ready", name), 32'(bus.div_ready), 32'(e_rdy));
        check($sformatf("%s busy", name),      32'(bus.busy),      32'(e_busy));
    endtask

    bit a_clk  [12] = '{0,0,0,0,1,1,0,0,1,1,0,0};
    bit a_tick [12] = '{0,0,0,0,1,0,0,0,1,0,0,0};
    bit c_clk  [14] = '{1,0,0,1,1,1,0,0,0,0,1,1,1,0};
    bit c_tick [14] = '{0,0,0,1,0,0,0,0,0,0,1,0,0,0};
    bit c_ack  [14] = '{0,0,0,1,0,0,0,0,0,0,0,0,0,0};
    bit c_rdy  [14] = '{0,0,0,1,1,1,1,1,1,1,1,1,1,1};
    bit e_clk  [7]  = '{0,0,0,0,1,1,0};
    bit e_tick [7]  = '{0,0,0,0,1,0,0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.div_req = 1'b0;
        bus.div_val = '0;

        // Reset values
        cyc("rst0", 1, 0, 0, 10'd0, 0, 0, 0, 0, 1, 0);
        cyc("rst1", 1, 1, 1, 10'd5, 0, 0, 0, 0, 1, 0);

        // Default ratio 4 from enable
        for (int i = 0; i < 12; i++)
            cyc($sformatf("div4[%0d]", i), 0, 1, 0, 10'd0, a_clk[i], a_tick[i], 0, 0, 1, 1);

        // Rejected ratios 1 and 0; period stays 4
        cyc("err1",  0, 1, 1, 10'd1, 1, 1, 0, 1, 1, 1);
        cyc("err0",  0, 1, 1, 10'd0, 1, 0, 0, 1, 1, 1);
        cyc("errp0", 0, 1, 0, 10'd0, 0, 0, 0, 0, 1, 1);
        cyc("errp1", 0, 1, 0, 10'd0, 0, 0, 0, 0, 1, 1);
        cyc("errp2", 0, 1, 0, 10'd0, 1, 1, 0, 0, 1, 1);

        // Request 7 mid-period, a second request of 9 while pending is ignored
        for (int i = 0; i < 14; i++) begin
            bit r;
            logic [9:0] v;
            r = (i < 2);
            v = (i == 0) ? 10'd7 : 10'd9;
            cyc($sformatf("div7[%0d]", i), 0, 1, r, v, c_clk[i], c_tick[i], c_ack[i], 0, c_rdy[i], 1);
        end

        // Stop behaviour at div 8, enable dropped while counter=1
        cyc("s_rst",  1, 0, 0, 10'd0, 0, 0, 0, 0, 1, 0);
        cyc("s_erp",  0, 0, 1, 10'd1, 0, 0, 0, 1, 1, 0);
        cyc("s_load", 0, 0, 1, 10'd8, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            cyc($sformatf("div8[%0d]", i), 0, 1, 0, 10'd0, (i >= 8), (i == 8), 0, 0, 1, 1);
`ifdef CLK_DIV_CTRL_SOFT_STOP_EN
        begin
            bit s_clk  [8] = '{1,1,0,0,0,0,0,0};
            bit s_busy [8] = '{1,1,1,1,1,1,0,0};
            for (int i = 0; i < 8; i++)
                cyc($sformatf("drain[%0d]", i), 0, 0, 0, 10'd0, s_clk[i], 0, 0, 0, 1, s_busy[i]);
        end
`else
        begin
            bit h_en   [7] = '{0,0,0,1,1,1,1};
            bit h_clk  [7] = '{1,1,1,1,1,1,0};
            bit h_busy [7] = '{0,0,0,1,1,1,1};
            for (int i = 0; i < 7; i++)
                cyc($sformatf("freeze[%0d]", i), 0, h_en[i], 0, 10'd0, h_clk[i], 0, 0, 0, 1, h_busy[i]);
        end
`endif

        // Reset with a pending ratio discards it; ratio returns to 4
        cyc("p_rst", 1, 0, 0, 10'd0, 0, 0, 0, 0, 1, 0);
        cyc("p_e0",  0, 1, 0, 10'd0, 0, 0, 0, 0, 1, 1);
        cyc("p_e1",  0, 1, 1, 10'd6, 0, 0, 0, 0, 0, 1);
        cyc("p_e2",  0, 1, 0, 10'd0, 0, 0, 0, 0, 0, 1);
        cyc("p_e3",  0, 1, 0, 10'd0, 0, 0, 0, 0, 0, 1);
        cyc("p_hit", 1, 1, 1, 10'd5, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++)
            cyc($sformatf("after[%0d]", i), 0, 1, 0, 10'd0, e_clk[i], e_tick[i], 0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter BIT_SIZE, default 10: width of the divide-ratio path.
REQ-002 Parameter DEFAULT_DIV, default 4: divide ratio loaded at reset (100 MHz -> 25 MHz).
REQ-003 Port clk_in  input  1: single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port enable  input  1: run request for the divided clock.
REQ-006 Port div_req  input  1: ratio-change request, sampled only while div_ready=1.
REQ-007 Port div_val  input  BIT_SIZE: requested divide ratio, valid with div_req.
REQ-008 Port div_ready  output  1: high when a new ratio request can be accepted.
REQ-009 Port div_ack  output  1: one-cycle pulse, new ratio now active.
REQ-010 Port div_err  output  1: one-cycle pulse, request rejected (div_val<2).
REQ-011 Port clk_out  output  1: registered divided clock.
REQ-012 Port tick  output  1: one-cycle pulse in the first clk_in cycle of each clk_out high phase.
REQ-013 Port busy  output  1: high in RUN or DRAIN.

Function
REQ-014 The block SHALL hold active_div (BIT_SIZE bits), pend_div, a pending flag, a counter 0..active_div-1 and a state register {STOP, RUN, DRAIN}.
REQ-015 In RUN the counter SHALL increment each cycle and wrap to 0 after active_div-1.
REQ-016 clk_out SHALL be set when counter=active_div-1 and cleared when counter=active_div/2-1 (integer division); high phase active_div/2 cycles, low phase active_div-active_div/2 cycles.
REQ-017 tick SHALL assert in the same cycle clk_out first reads 1 of each period.
REQ-018 STOP->RUN when enable=1; first clk_out rise SHALL occur active_div cycles after entering RUN.
REQ-019 RUN->stop behaviour on enable=0 SHALL follow the Configuration section.
REQ-020 div_ready SHALL be 1 when no request is pending and 0 otherwise.
REQ-021 div_req with div_ready=1 and div_val<2 SHALL produce div_err the next cycle and change nothing else.
REQ-022 Valid request in STOP: active_div SHALL load next cycle, counter to 0, div_ack pulses that cycle.
REQ-023 Valid request in RUN/DRAIN: pend_div captured, pending set, div_ready low next cycle.
REQ-024 Pending ratio SHALL apply only at the wrap edge (counter=active_div-1): active_div<=pend_div, counter<=0, pending cleared, div_ack pulses in the cycle after that edge; no truncated clk_out phase.
REQ-025 div_req while div_ready=0 SHALL be ignored (no ack, no err, pend_div unchanged).
REQ-026 Enable falling while pending: pending ratio still applies at the next wrap or on entry to STOP, whichever is first.
REQ-027 div_ack and div_err SHALL never assert in the same cycle.

Reset
REQ-028 On reset=1 at a clk_in edge: state=STOP, counter=0, clk_out=0, tick=0, busy=0, div_ack=0, div_err=0, div_ready=1, active_div=DEFAULT_DIV, pending cleared.
REQ-029 Reset mid-period or with a pending request SHALL discard the pending ratio without div_ack.
REQ-030 Reset SHALL take priority over enable and div_req in the same cycle.

Configuration
REQ-031 Macro CLK_DIV_CTRL_SOFT_STOP_EN SHALL select stop behaviour.
REQ-032 Defined: enable=0 in RUN enters DRAIN; counting continues to the wrap edge, then STOP with clk_out=0, counter=0; enable=1 in DRAIN returns to RUN with no phase disturbance.
REQ-033 Undefined: enable=0 in RUN enters STOP next cycle; counter and clk_out freeze at current values; DRAIN is unreachable; resuming continues from frozen counter.

Verification
REQ-034 Reset, enable=1, DEFAULT_DIV=4 -> clk_out 0,0,0,0,1,1,0,0,1,1...; tick once per 4 cycles aligned with each rise.
REQ-035 In RUN at div 4, request div_val=7 mid-period -> div_ready low, current period completes, then high 3 / low 4 cycles; div_ack one pulse after the wrap edge.
REQ-036 div_val=1 and div_val=0 requests -> div_err pulse each, clk_out period stays 4, no div_ack.
REQ-037 Second request (div_val=9) while pending 7 -> ignored; final ratio 7.
REQ-038 enable=0 at counter=1, div 8 -> with SOFT_STOP_EN: runs to counter 7, clk_out ends 0, busy falls; without: clk_out and counter frozen next cycle.
REQ-039 reset=1 with pending request at counter=3 -> all outputs at reset values next cycle, active_div=4, no div_ack.
